// File: rtl/up_dn_sweep_ctrl.sv
// up_dn_sweep_ctrl: drives an external up/down counter through bounded
// triangle sweeps (Lo_Lim..Hi_Lim) with dwell at each end.
// Ports:
//   CLK, RST            clock, async active-high reset
//   Start, Abort        sweep request (IDLE only) / terminate sweep
//   Start_Val, Lo_Lim,
//   Hi_Lim, Cycles      sweep config, captured when Start is accepted
//   Counter, High, Low  counter feedback
//   Up, Down, Load, IN  counter commands and load value
//   Busy, Done, Err     status; Done/Err are one-cycle pulses
//   Sweep_Cnt           completed sweeps (4-bit wrap)
module up_dn_sweep_ctrl #(
    parameter int WIDTH = 5,
    parameter int DWELL = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] Start_Val,
    input  logic [WIDTH-1:0] Lo_Lim,
    input  logic [WIDTH-1:0] Hi_Lim,
    input  logic [3:0]       Cycles,
    input  logic [WIDTH-1:0] Counter,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [WIDTH-1:0] IN,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [3:0]       Sweep_Cnt
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sv_r, lo_r, hi_r, exp_r;
    logic [3:0]       cyc_r, cnt_r, cnt_nx;
    logic [DW-1:0]    dcnt;
    logic             accept, cnt_inc, err_n, done_n;
    logic             cfg_ok, tracking, mismatch, dlast;

    assign cfg_ok = (Lo_Lim < Hi_Lim) && (Start_Val >= Lo_Lim)
                 && (Start_Val <= Hi_Lim);
    assign cnt_nx = cnt_r + 4'd1;
    assign dlast = (dcnt == D_LAST);
    assign tracking = (state == S_UP) || (state == S_DWELL_HI)
                   || (state == S_DOWN) || (state == S_DWELL_LO);
    // Counter must always agree with the value we believe we commanded
    assign mismatch = tracking && (Counter != exp_r);
    assign Busy = (state != S_IDLE);
    assign Sweep_Cnt = cnt_r;

    always_comb begin
        state_n = state;
        Up      = 1'b0;
        Down    = 1'b0;
        Load    = 1'b0;
        IN      = '0;
        accept  = 1'b0;
        cnt_inc = 1'b0;
        err_n   = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    if (cfg_ok) begin
                        accept  = 1'b1;
                        state_n = S_LOAD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                Load    = 1'b1;
                IN      = sv_r;
                state_n = S_UP;
            end
            S_UP: begin
                if (Counter == hi_r) state_n = S_DWELL_HI;
                else                 Up = ~High;
            end
            S_DWELL_HI: begin
                if (dlast) state_n = S_DOWN;
            end
            S_DOWN: begin
                if (Counter == lo_r) begin
                    cnt_inc = 1'b1;
                    if (cyc_r != 4'd0 && cnt_nx == cyc_r)
                        state_n = S_DONE;
                    else
                        state_n = S_DWELL_LO;
                end else begin
                    Down = ~Low;
                end
            end
            S_DWELL_LO: begin
                if (dlast) state_n = S_UP;
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort or tracking loss kills commands this cycle and
        // returns to IDLE without counting or completing the sweep
        if (Busy && (Abort || mismatch)) begin
            Up      = 1'b0;
            Down    = 1'b0;
            Load    = 1'b0;
            cnt_inc = 1'b0;
            done_n  = 1'b0;
            err_n   = mismatch;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            Err   <= 1'b0;
            Done  <= 1'b0;
            sv_r  <= '0;
            lo_r  <= '0;
            hi_r  <= '0;
            exp_r <= '0;
            cyc_r <= '0;
            cnt_r <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            Err   <= err_n;
            Done  <= done_n;
            if (accept) begin
                sv_r  <= Start_Val;
                lo_r  <= Lo_Lim;
                hi_r  <= Hi_Lim;
                cyc_r <= Cycles;
                cnt_r <= 4'd0;
                exp_r <= Start_Val;
            end else begin
                if (cnt_inc) cnt_r <= cnt_nx;
                if (Up)        exp_r <= exp_r + ONE;
                else if (Down) exp_r <= exp_r - ONE;
            end
            if ((state == S_DWELL_HI || state == S_DWELL_LO)
                && state_n == state)
                dcnt <= dcnt + DW'(1);
            else
                dcnt <= '0;
        end
    end

endmodule
